// File: rtl/pe_switch_ctx_seq.sv
// Context sequencer driving the PE 5x4 crossbar switch word.
// Loads contexts over a valid/ready stream and replays them on start.
module pe_switch_ctx_seq #(
   parameter int CTX_DEPTH = 8,
   parameter int SW_W      = 12,
   parameter int IDX_W     = $clog2(CTX_DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [SW_W-1:0]  cfg_data,
   input  logic             cfg_last,
   input  logic [15:0]      loop_count,
   input  logic             start,
   input  logic             stop,
   output logic [SW_W-1:0]  switch,
   output logic [IDX_W-1:0] ctx_idx,
   output logic             busy,
   output logic             done,
   output logic             loaded,
   output logic             cfg_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(CTX_DEPTH);

   state_t          state;
   logic [SW_W-1:0] ctx_mem [CTX_DEPTH];
   logic [IDX_W:0]  wr_cnt;
   logic [IDX_W:0]  num_ctx;
   logic            first;
   logic [15:0]     iter;
   logic [15:0]     loop_q;

   logic            accept;
   logic            ovf;
   logic            fld_bad;
   logic [SW_W-1:0] cfg_fix;
   logic            last_ctx;
   logic            last_iter;
   logic [IDX_W-1:0] nxt_idx;

   assign cfg_ready = (state == S_IDLE) & ~start;
   assign accept    = cfg_valid & cfg_ready;
   assign ovf       = (wr_cnt == DEPTH);

   // Out-of-range selects are clamped to the LSU port (4).
   always_comb begin
      cfg_fix = cfg_data;
      fld_bad = 1'b0;
      for (int f = 0; f < SW_W / 3; f++) begin
         if (cfg_data[3*f +: 3] > 3'd4) begin
            cfg_fix[3*f +: 3] = 3'd4;
            fld_bad = 1'b1;
         end
      end
   end

   assign last_ctx  = ({1'b0, ctx_idx} == (num_ctx - 1'b1));
   assign last_iter = (loop_q != 16'd0) && (iter == (loop_q - 16'd1));
   assign nxt_idx   = last_ctx ? '0 : ctx_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (accept && !ovf) begin
         ctx_mem[wr_cnt[IDX_W-1:0]] <= cfg_fix;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         switch  <= '0;
         ctx_idx <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         loaded  <= 1'b0;
         cfg_err <= 1'b0;
         wr_cnt  <= '0;
         num_ctx <= '0;
         first   <= 1'b1;
         iter    <= '0;
         loop_q  <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            if (first) begin
               loaded  <= 1'b0;
               cfg_err <= fld_bad;
            end else begin
               cfg_err <= cfg_err | fld_bad | ovf;
            end
            first <= cfg_last;
            if (cfg_last) begin
               num_ctx <= ovf ? DEPTH : wr_cnt + 1'b1;
               loaded  <= 1'b1;
               wr_cnt  <= '0;
            end else if (!ovf) begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end
         unique case (state)
            S_IDLE: begin
               if (start && loaded) begin
                  state   <= S_RUN;
                  busy    <= 1'b1;
                  switch  <= ctx_mem[0];
                  ctx_idx <= '0;
                  iter    <= '0;
                  loop_q  <= loop_count;
               end
            end
            S_RUN: begin
               if (stop || (last_ctx && last_iter)) begin
                  state   <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  switch  <= '0;
                  ctx_idx <= '0;
               end else begin
                  ctx_idx <= nxt_idx;
                  switch  <= ctx_mem[nxt_idx];
                  if (last_ctx) begin
                     iter <= iter + 16'd1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_switch_ctx_seq.sv
// Randomized self-checking bench for pe_switch_ctx_seq.
// Reference model keeps the program as a queue of sanitized words.
module tb_pe_switch_ctx_seq;
   localparam int DEPTH = 8;
   localparam int SW_W  = 12;
   localparam int IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [SW_W-1:0]  cfg_data = '0;
   logic             cfg_last = 1'b0;
   logic [15:0]      loop_count = '0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [SW_W-1:0]  switch;
   logic [IDX_W-1:0] ctx_idx;
   logic             busy;
   logic             done;
   logic             loaded;
   logic             cfg_err;

   pe_switch_ctx_seq #(
      .CTX_DEPTH(DEPTH),
      .SW_W     (SW_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_data  (cfg_data),
      .cfg_last  (cfg_last),
      .loop_count(loop_count),
      .start     (start),
      .stop      (stop),
      .switch    (switch),
      .ctx_idx   (ctx_idx),
      .busy      (busy),
      .done      (done),
      .loaded    (loaded),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [11:0] prog[$];
   logic [11:0] cur[$];
   bit m_loaded = 0;
   bit m_err = 0;
   bit m_first = 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] legal(input logic [11:0] d);
      logic [11:0] r;
      r = d;
      for (int f = 0; f < 4; f++) begin
         if (d[3*f +: 3] > 3'd4) r[3*f +: 3] = 3'd4;
      end
      return r;
   endfunction

   task automatic model_reset();
      prog.delete();
      cur.delete();
      m_loaded = 0;
      m_err = 0;
      m_first = 1;
   endtask

   task automatic model_accept(input logic [11:0] d, input bit last);
      logic [11:0] s;
      if (m_first) begin
         cur.delete();
         m_loaded = 0;
         m_err = 0;
         m_first = 0;
      end
      s = legal(d);
      if (s != d) m_err = 1;
      if (cur.size() < DEPTH) cur.push_back(s);
      else m_err = 1;
      if (last) begin
         prog = cur;
         m_loaded = 1;
         m_first = 1;
      end
   endtask

   task automatic load(input logic [11:0] d, input bit last);
      cfg_data = d;
      cfg_last = last;
      cfg_valid = 1'b1;
      #1;
      vectors++;
      if (cfg_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL load_ready: got %b want 1", cfg_ready);
      end
      tick();
      cfg_valid = 1'b0;
      cfg_last = 1'b0;
      model_accept(d, last);
      vectors++;
      if (cfg_err !== m_err) begin
         miscompares++;
         $display("FAIL load_err: got %b want %b", cfg_err, m_err);
      end
      vectors++;
      if (loaded !== m_loaded) begin
         miscompares++;
         $display("FAIL load_loaded: got %b want %b", loaded, m_loaded);
      end
   endtask

   task automatic run(input int lc, input int stop_at);
      int n;
      int total;
      bit use_stop;
      logic [11:0] exp_sw;
      logic [IDX_W-1:0] exp_idx;
      n = prog.size();
      total = (lc == 0) ? stop_at : n * lc;
      use_stop = (lc == 0);
      if (stop_at > 0 && stop_at < total) begin
         total = stop_at;
         use_stop = 1;
      end
      loop_count = lc[15:0];
      start = 1'b1;
      tick();
      start = 1'b0;
      loop_count = 16'($urandom);
      for (int c = 0; c < total; c++) begin
         exp_sw = prog[c % n];
         exp_idx = IDX_W'(c % n);
         vectors++;
         if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL run_busy c=%0d: got %b want 1", c, busy);
         end
         vectors++;
         if (switch !== exp_sw) begin
            miscompares++;
            $display("FAIL run_switch c=%0d: got %h want %h", c, switch, exp_sw);
         end
         vectors++;
         if (ctx_idx !== exp_idx) begin
            miscompares++;
            $display("FAIL run_idx c=%0d: got %0d want %0d", c, ctx_idx, exp_idx);
         end
         vectors++;
         if (cfg_ready !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL run_ready_done c=%0d: got %b%b want 00", c, cfg_ready, done);
         end
         cfg_valid = 1'($urandom);
         cfg_last = 1'b1;
         cfg_data = 12'($urandom);
         if (use_stop && c == total - 1) stop = 1'b1;
         tick();
         stop = 1'b0;
         cfg_valid = 1'b0;
         cfg_last = 1'b0;
      end
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || switch !== '0) begin
         miscompares++;
         $display("FAIL run_done: got done=%b busy=%b sw=%h want 1 0 000", done, busy, switch);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || loaded !== m_loaded) begin
         miscompares++;
         $display("FAIL run_idle: got done=%b busy=%b loaded=%b want 0 0 %b", done, busy, loaded, m_loaded);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      vectors++;
      if ({switch, ctx_idx, busy, done, loaded, cfg_err, cfg_ready} !== {12'h000, 3'd0, 5'b00001}) begin
         miscompares++;
         $display("FAIL reset_state: got sw=%h idx=%0d b=%b d=%b l=%b e=%b r=%b want 000 0 0 0 0 0 1",
                  switch, ctx_idx, busy, done, loaded, cfg_err, cfg_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      tick();
   endtask

   task automatic test_collision();
      start = 1'b1;
      cfg_valid = 1'b1;
      cfg_last = 1'b1;
      cfg_data = 12'h111;
      #1;
      vectors++;
      if (cfg_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL collide_ready: got %b want 0", cfg_ready);
      end
      tick();
      start = 1'b0;
      cfg_valid = 1'b0;
      cfg_last = 1'b0;
      vectors++;
      if (loaded !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL collide_state: got loaded=%b busy=%b want 0 0", loaded, busy);
      end
   endtask

   task automatic test_single();
      load(12'h000, 0);
      load(12'h249, 0);
      load(12'h492, 1);
      run(1, 0);
   endtask

   task automatic test_multi();
      run(3, 0);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 10; i++) load(legal(12'($urandom)), i == 9);
      run(1, 0);
   endtask

   task automatic test_illegal();
      load(12'hFFF, 1);
      run(2, 0);
      load(12'h0A1, 0);
      load(12'h123, 1);
      run(1, 0);
   endtask

   task automatic test_stop_forever();
      load(12'h001, 0);
      load(12'h00A, 0);
      load(12'h0C3, 1);
      run(0, 20);
      run(1, 0);
   endtask

   task automatic test_reset_mid();
      load(12'h111, 0);
      load(12'h222, 1);
      loop_count = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({switch, ctx_idx, busy, done, loaded, cfg_err, cfg_ready} !== {12'h000, 3'd0, 5'b00001}) begin
         miscompares++;
         $display("FAIL midrst_state: got sw=%h idx=%0d b=%b d=%b l=%b e=%b r=%b want 000 0 0 0 0 0 1",
                  switch, ctx_idx, busy, done, loaded, cfg_err, cfg_ready);
      end
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (busy !== 1'b0 || switch !== '0) begin
         miscompares++;
         $display("FAIL midrst_start: got busy=%b sw=%h want 0 000", busy, switch);
      end
   endtask

   task automatic test_random();
      int n;
      int lc;
      int sa;
      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(1, 11);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            load(12'($urandom), i == n - 1);
         end
         lc = $urandom_range(0, 3);
         if (lc == 0) sa = $urandom_range(1, 25);
         else if ($urandom_range(0, 2) == 0) sa = $urandom_range(1, prog.size() * lc);
         else sa = 0;
         run(lc, sa);
      end
   endtask

   initial begin
      test_reset();
      test_collision();
      test_single();
      test_multi();
      test_overflow();
      test_illegal();
      test_stop_forever();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pe_switch_ctx_seq.md
# pe_switch_ctx_seq

Context sequencer that produces the 12-bit `switch` word consumed by the PE 5x4 routing crossbar. It accepts routing contexts from the configuration network over a valid/ready stream and stores up to `CTX_DEPTH` of them. On `start` it replays the contexts cycle-by-cycle for a programmed number of iterations, then returns to a safe idle route. It sits beside each PE, between the array configuration bus and the crossbar's `switch` input.

## Interface

**Parameters**
- `CTX_DEPTH`, default 8: number of context slots. Power of two, 2 to 16.
- `SW_W`, default 12: switch word width. Equals `` `PE_5x4 ``.
- `IDX_W`, default `$clog2(CTX_DEPTH)`: width of the context index.

**Ports** (clock and reset first)
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `cfg_valid`, input, 1: a configuration word is offered.
- `cfg_ready`, output, 1: the block accepts the word this cycle.
- `cfg_data`, input, `SW_W`: context word, laid out as {N_sel[11:9], S_sel[8:6], W_sel[5:3], E_sel[2:0]}.
- `cfg_last`, input, 1: marks the final word of a program.
- `loop_count`, input, 16: number of iterations, sampled at `start`. A value of 0 means run until `stop`.
- `start`, input, 1: one-cycle pulse that begins replay.
- `stop`, input, 1: aborts replay.
- `switch`, output, `SW_W`: registered crossbar select word.
- `ctx_idx`, output, `IDX_W`: index of the context currently driven on `switch`.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse when replay completes or aborts.
- `loaded`, output, 1: a complete program is held.
- `cfg_err`, output, 1: sticky error flag. Cleared by reset or by the first word of a new program.

## Operation

**States**

- **IDLE**
  - `switch` = 0, which routes every output from `din_N`.
  - `cfg_ready = ~start`.
  - A word is accepted when `cfg_valid & cfg_ready`. It is written to slot `wr_ptr`, then `wr_ptr` increments.
  - The first word accepted after reset, or after a `cfg_last`, starts a new program: it is written at slot 0, clears `loaded` and clears `cfg_err`.
  - When a word is accepted with `cfg_last` high: `num_ctx = wr_ptr + 1`, `loaded` is set, and `wr_ptr` resets to 0.
- **Overflow**
  - Words beyond `CTX_DEPTH` without a `cfg_last` are still accepted (handshake completes) but dropped, and `cfg_err` is set.
  - A later `cfg_last` then sets `num_ctx = CTX_DEPTH` and sets `loaded`.
- **Field check**
  - Any 3-bit select field greater than 4 is stored as 4 (LSU) and sets `cfg_err`.
- **IDLE to RUN**
  - Taken on `start` when `loaded` = 1.
  - `start` while `loaded` = 0 is ignored. `start` outside IDLE is ignored.
- **RUN**
  - `cfg_ready` = 0 and `busy` = 1.
  - Each cycle, `switch` = ctx[`idx`] and `ctx_idx` = `idx`.
  - `idx` wraps from `num_ctx - 1` to 0. Each wrap increments the 16-bit `iter` counter.
  - Exit to DONE when the wrap occurs with `iter == loop_count_q - 1` and `loop_count_q != 0`.
  - Exit to DONE on `stop`. `stop` has priority over a normal wrap in the same cycle.
- **DONE**
  - Lasts one cycle: `done` = 1, `switch` = 0, `busy` = 0.
  - Next state is IDLE. `loaded` is retained, so the program can be restarted.

**Arithmetic and width rules**
- `iter` is 16 bits and never exceeds `loop_count_q - 1` in counted mode.
- In forever mode (`loop_count` = 0), `iter` wraps modulo 2^16.
- `num_ctx` is stored in `IDX_W + 1` bits.

## Timing

- **Reset values:** `switch` = 0, `ctx_idx` = 0, `busy` = 0, `done` = 0, `loaded` = 0, `cfg_err` = 0, `cfg_ready` = 1, and the FSM is in IDLE.
- **Context storage:** contents are unreset and need not be cleared.
- **Start latency:** `start` is sampled at edge T; `switch` shows ctx[0] and `busy` = 1 from T+1.
- **Cycle count:** a run of N contexts and L iterations occupies exactly N·L cycles of RUN.
- **Done:** the cycle after the last context, `done` = 1 and `switch` = 0.
- **Stop latency:** `stop` sampled at T gives `done` and `switch` = 0 at T+1.
- **Handshake:** the transfer occurs on the edge where `cfg_valid & cfg_ready`. `cfg_data` is captured with no combinational path to any output.
- **`cfg_ready` timing:** it is driven from state and `start` only, and never depends on `cfg_valid`.
- **Reset mid-operation:** an asynchronous `rst_n` assertion forces all outputs to their reset values immediately. The program is lost (`loaded` = 0).
- **`start` and `cfg_valid` in the same IDLE cycle:** `start` wins and no word is accepted.

## Test plan

- **Load and single replay:** load 3 words 0x000, 0x249, 0x492 (last on the third), `loop_count` = 1, pulse `start` → `switch` = 0x000, 0x249, 0x492 on consecutive cycles, `ctx_idx` 0,1,2, then `done` = 1 with `switch` = 0, then IDLE.
- **Multi-iteration:** the same program with `loop_count` = 3 → 9 RUN cycles, `ctx_idx` follows 0,1,2 repeated, a single `done` pulse.
- **Overflow:** 10 words with `CTX_DEPTH` = 8 and last on word 10 → all 10 handshakes complete, `cfg_err` = 1, `num_ctx` = 8, and replay shows words 1–8 only.
- **Illegal field:** load 0xFFF (last) → stored value replays as 0x924 and `cfg_err` = 1. Loading a new program clears `cfg_err`.
- **Stop and forever mode:** `loop_count` = 0, `stop` after 20 RUN cycles → `done` on the next cycle, `switch` = 0, `loaded` still 1. A second `start` replays from ctx[0].
- **Reset and collision:** assert `rst_n` low mid-RUN → outputs reset asynchronously and `start` afterwards is ignored (`loaded` = 0). Separately, `start` together with `cfg_valid` in IDLE gives `cfg_ready` = 0 and no word written.
